// File: rtl/mod_sequencer.sv
// Segment-table modulation sequencer: plays {half_period, dwell} entries in order,
// holding each for max(dwell,1)*TICK_DIV cycles, optionally looping.
module mod_sequencer #(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [15:0]              cfg_half_period,
  input  logic [15:0]              cfg_dwell,
  input  logic [$clog2(DEPTH):0]   cfg_count,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     mod_enable,
  output logic [15:0]              mod_half_period,
  output logic [$clog2(DEPTH)-1:0] seg_idx,
  output logic                     seg_strobe,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef struct packed {
    logic [15:0] half_period;
    logic [15:0] dwell;
  } seg_entry_t;

  typedef enum logic {IDLE, RUN} state_t;

  seg_entry_t    tbl [DEPTH];
  state_t        state, state_nx;
  logic [AW-1:0] idx, idx_nx, ld_idx;
  logic [15:0]   half, half_nx, dwell_cnt, dwell_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [AW:0]   cnt_l, cnt_nx, cnt_m1;
  logic          loop_l, loop_nx, strobe_nx, done_nx;
  logic          load, tick, last, start_ok;
  seg_entry_t    ld_ent;

  // Table has no reset; software must load it before start.
  always_ff @(posedge clk)
    if (cfg_we) tbl[cfg_addr] <= '{half_period: cfg_half_period, dwell: cfg_dwell};

  assign cnt_m1   = cnt_l - {{AW{1'b0}}, 1'b1};
  assign tick     = (presc == TICK_LAST);
  assign last     = ({1'b0, idx} == cnt_m1);
  assign start_ok = start && !stop && (cfg_count != '0) && (cfg_count <= DEPTH_C);

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    half_nx   = half;
    dwell_nx  = dwell_cnt;
    presc_nx  = presc;
    cnt_nx    = cnt_l;
    loop_nx   = loop_l;
    strobe_nx = 1'b0;
    done_nx   = 1'b0;
    load      = 1'b0;
    ld_idx    = '0;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = RUN;
          cnt_nx   = cfg_count;
          loop_nx  = loop_en;
          load     = 1'b1;
        end
      end
      RUN: begin
        // Stop outranks any segment advance due in the same cycle.
        if (stop) begin
          state_nx = IDLE;
          idx_nx   = '0;
          half_nx  = '0;
          dwell_nx = '0;
          presc_nx = '0;
        end else if (!tick) begin
          presc_nx = presc + PW'(1);
        end else if (dwell_cnt > 16'd1) begin
          dwell_nx = dwell_cnt - 16'd1;
          presc_nx = '0;
        end else if (!last) begin
          load   = 1'b1;
          ld_idx = idx + AW'(1);
        end else if (loop_l) begin
          load   = 1'b1;
        end else begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          idx_nx   = '0;
          half_nx  = '0;
          dwell_nx = '0;
          presc_nx = '0;
        end
      end
    endcase
    // Entry is captured at load, so later table writes never touch the live segment.
    ld_ent = tbl[ld_idx];
    if (load) begin
      idx_nx    = ld_idx;
      half_nx   = ld_ent.half_period;
      dwell_nx  = (ld_ent.dwell == 16'd0) ? 16'd1 : ld_ent.dwell;
      presc_nx  = '0;
      strobe_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      half       <= '0;
      dwell_cnt  <= '0;
      presc      <= '0;
      cnt_l      <= '0;
      loop_l     <= 1'b0;
      seg_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      half       <= half_nx;
      dwell_cnt  <= dwell_nx;
      presc      <= presc_nx;
      cnt_l      <= cnt_nx;
      loop_l     <= loop_nx;
      seg_strobe <= strobe_nx;
      done       <= done_nx;
    end
  end

  assign busy            = (state == RUN);
  assign mod_enable      = busy;
  assign mod_half_period = half;
  assign seg_idx         = idx;

endmodule
